// File: rtl/mem_master.sv
// Burst initiator for the single-port memory bus: turns read/write burst commands
// into per-word re_en/wr_en strobes and returns read words with valid/last.
module mem_master #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 13,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_re_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;

  state_t             state;
  state_t             next_state;
  logic [ADDR_W-1:0]  cur_addr;
  logic [LEN_W-1:0]   remaining;
  logic               pending;
  logic               pending_last;
  logic               accept;
  logic               issue_rd;
  logic               issue_wr;
  logic               last_word;

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == WRITE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // DRAIN only holds until the final read word lands in rsp_data.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    issue_rd   = 1'b0;
    issue_wr   = 1'b0;
    last_word  = (remaining == '0);
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          next_state = cmd_we ? WRITE : READ;
        end
      end
      READ: begin
        issue_rd = 1'b1;
        if (last_word) next_state = DRAIN;
      end
      DRAIN: begin
        if (pending && pending_last) next_state = IDLE;
      end
      WRITE: begin
        if (wr_valid) begin
          issue_wr = 1'b1;
          if (last_word) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // pending tracks the word the memory returns during the cycle after each strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr     <= '0;
      remaining    <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
      mem_address  <= '0;
      mem_re_en    <= 1'b0;
      mem_wr_en    <= 1'b0;
      mem_wdata    <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_last     <= 1'b0;
    end else begin
      mem_re_en    <= issue_rd;
      mem_wr_en    <= issue_wr;
      pending      <= issue_rd;
      pending_last <= issue_rd && last_word;
      rsp_valid    <= pending;
      rsp_last     <= pending && pending_last;
      if (pending) rsp_data <= mem_rdata;
      if (accept) begin
        cur_addr  <= cmd_addr;
        remaining <= cmd_len;
      end else if (issue_rd || issue_wr) begin
        mem_address <= cur_addr;
        cur_addr    <= cur_addr + ADDR_W'(1);
        remaining   <= remaining - LEN_W'(1);
      end
      if (issue_wr) mem_wdata <= wr_data;
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: directed table, hand-written corner sequences and random
// bursts, all checked against a transaction-level model of memory contents.
module tb_mem_master;

  localparam int DATA_W = 18;
  localparam int ADDR_W = 13;
  localparam int LEN_W  = 3;
  localparam int DEPTH  = 8192;

  typedef logic [31:0] word_q[$];

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    int                stallAfter;
    int                stallCycles;
    int                expBeats;
    logic [31:0]       expEndAddr;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              busy;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_re_en;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] refMem [DEPTH];
  logic [DATA_W-1:0] wbuf [8];

  int nCompared = 0;
  int nFailed   = 0;
  int cyc       = 0;
  int hcyc;
  int doneCyc;
  int idleCyc;
  int beats;
  logic [31:0] lastA;
  logic [31:0] rnd;
  vec_t vecs [7];

  word_q gotWrAddr, gotWrData, gotRdAddr, gotRspData, gotRspLast, gotRspCyc;
  word_q expWrAddr, expWrData, expRdAddr, expRspData, expRspLast, expRspCyc;

  mem_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy),
    .mem_address(mem_address), .mem_re_en(mem_re_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] pattern(input int i);
    logic [31:0] t;
    t = i * 37 + 5;
    return t[DATA_W-1:0];
  endfunction

  // Memory device: asynchronous read, write on the clock edge after the strobe.
  assign mem_rdata = mem[mem_address];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = pattern(i);
    mem[20] = 18'd42;
    forever begin
      @(posedge clk);
      if (mem_wr_en) mem[mem_address] <= mem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor: records every strobe and response beat with its cycle number.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_re_en || mem_wr_en) begin
        nCompared++;
        if (mem_re_en && mem_wr_en) begin
          nFailed++;
          $display("[TB] FAIL strobe_exclusive: got re_en=1 wr_en=1 expected at most one");
        end
      end
      if (mem_wr_en) begin
        gotWrAddr.push_back(32'(mem_address));
        gotWrData.push_back(32'(mem_wdata));
      end
      if (mem_re_en) gotRdAddr.push_back(32'(mem_address));
      if (rsp_valid) begin
        gotRspData.push_back(32'(rsp_data));
        gotRspLast.push_back(32'(rsp_last));
        gotRspCyc.push_back(32'(cyc));
      end
    end
  end

  task automatic compareQ(input string name, input word_q got, input word_q exp);
    checkOutput({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      checkOutput($sformatf("%s[%0d]", name, i), got[i], exp[i]);
  endtask

  task automatic checkQueues();
    compareQ("wr_addr", gotWrAddr, expWrAddr);
    compareQ("wr_data", gotWrData, expWrData);
    compareQ("rd_addr", gotRdAddr, expRdAddr);
    compareQ("rsp_data", gotRspData, expRspData);
    compareQ("rsp_last", gotRspLast, expRspLast);
    compareQ("rsp_cycle", gotRspCyc, expRspCyc);
    gotWrAddr.delete();  gotWrData.delete();  gotRdAddr.delete();
    gotRspData.delete(); gotRspLast.delete(); gotRspCyc.delete();
    expWrAddr.delete();  expWrData.delete();  expRdAddr.delete();
    expRspData.delete(); expRspLast.delete(); expRspCyc.delete();
  endtask

  // Issues one burst (write words from wbuf) and updates the reference model.
  // Entered and left 1 time unit after a rising edge.
  task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [LEN_W-1:0] len,
                               input int stallAfter, input int stallCycles);
    int k;
    logic [ADDR_W-1:0] a;
    logic [31:0] r;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = len;
    k = 0;
    while (!cmd_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    hcyc = cyc;
    cmd_valid = 1'b0;
    r = $urandom();
    cmd_we   = r[0];
    cmd_addr = r[13:1];
    cmd_len  = r[16:14];
    for (int i = 0; i <= int'(len); i++) begin
      a = ADDR_W'((int'(addr) + i) % DEPTH);
      if (we) begin
        expWrAddr.push_back(32'(a));
        expWrData.push_back(32'(wbuf[i]));
        refMem[a] = wbuf[i];
      end else begin
        expRdAddr.push_back(32'(a));
        expRspData.push_back(32'(refMem[a]));
        expRspLast.push_back((i == int'(len)) ? 32'd1 : 32'd0);
        expRspCyc.push_back(32'(hcyc + 2 + i));
      end
    end
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    checkOutput("cmd_ready_in_burst", 32'(cmd_ready), 32'd0);
    if (we) begin
      for (int i = 0; i <= int'(len); i++) begin
        if (stallCycles > 0 && i == stallAfter + 1) begin
          wr_valid = 1'b0;
          r = $urandom();
          wr_data = r[DATA_W-1:0];
          repeat (stallCycles) begin
            @(posedge clk); #1;
          end
        end
        checkOutput("wr_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_data  = wbuf[i];
        @(posedge clk); #1;
      end
      wr_valid = 1'b0;
      r = $urandom();
      wr_data = r[DATA_W-1:0];
    end
    k = 0;
    while (busy && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("busy_drop", 32'(busy), 32'd0);
    doneCyc = cyc;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 13'd20,    3'd0, 0,  0, 1, 32'd20};
    vecs[1] = '{1'b1, 13'd100,   3'd3, 1,  2, 4, 32'd103};
    vecs[2] = '{1'b0, 13'd100,   3'd3, 0,  0, 4, 32'd103};
    vecs[3] = '{1'b0, 13'h1FFE,  3'd3, 0,  0, 4, 32'h0001};
    vecs[4] = '{1'b1, 13'h1FFF,  3'd1, -1, 1, 2, 32'h0000};
    vecs[5] = '{1'b0, 13'h1FFF,  3'd1, 0,  0, 2, 32'h0000};
    vecs[6] = '{1'b0, 13'd0,     3'd7, 0,  0, 8, 32'd7};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = pattern(i);
    refMem[20] = 18'd42;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_re_en", 32'(mem_re_en), 32'd0);
    checkOutput("reset_wr_en", 32'(mem_wr_en), 32'd0);
    checkOutput("reset_address", 32'(mem_address), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-word read of a preloaded location, with exact latency.
    applyStimulus(1'b0, 13'd20, 3'd0, 0, 0);
    @(negedge clk); #1;
    checkOutput("t1_rsp_count", gotRspData.size(), 32'd1);
    if (gotRspData.size() > 0) begin
      checkOutput("t1_data", gotRspData[0], 32'd42);
      checkOutput("t1_last", gotRspLast[0], 32'd1);
      checkOutput("t1_latency", gotRspCyc[0], 32'(hcyc + 2));
    end
    checkQueues();
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 8; i++) wbuf[i] = DATA_W'(i + 1);
      applyStimulus(vecs[v].we, vecs[v].addr, vecs[v].len, vecs[v].stallAfter, vecs[v].stallCycles);
      @(negedge clk); #1;
      beats = vecs[v].we ? gotWrAddr.size() : gotRspData.size();
      checkOutput($sformatf("vec%0d_beats", v), 32'(beats), 32'(vecs[v].expBeats));
      lastA = '1;
      if (vecs[v].we && gotWrAddr.size() > 0) lastA = gotWrAddr[$];
      if (!vecs[v].we && gotRdAddr.size() > 0) lastA = gotRdAddr[$];
      checkOutput($sformatf("vec%0d_end_addr", v), lastA, vecs[v].expEndAddr);
      checkQueues();
      @(posedge clk); #1;
    end

    // Write immediately followed by a read of the same word, no idle gap.
    wbuf[0] = 18'h2ABCD;
    applyStimulus(1'b1, 13'd500, 3'd0, 0, 0);
    idleCyc = doneCyc;
    applyStimulus(1'b0, 13'd500, 3'd0, 0, 0);
    checkOutput("b2b_accept_cycle", 32'(hcyc), 32'(idleCyc + 1));
    @(negedge clk); #1;
    checkQueues();
    @(posedge clk); #1;

    // Reset in the middle of a long read: in-flight words must vanish.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 13'd300; cmd_len = 3'd7;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_last", 32'(rsp_last), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_re_en", 32'(mem_re_en), 32'd0);
    checkOutput("rst_wr_en", 32'(mem_wr_en), 32'd0);
    checkOutput("rst_address", 32'(mem_address), 32'd0);
    checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    gotWrAddr.delete();  gotWrData.delete();  gotRdAddr.delete();
    gotRspData.delete(); gotRspLast.delete(); gotRspCyc.delete();
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("post_reset_rsp_count", gotRspData.size(), 32'd0);
    checkOutput("post_reset_rd_count", gotRdAddr.size(), 32'd0);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);
    checkQueues();

    // Random bursts, sometimes chained back-to-back before checking.
    for (int n = 0; n < 40; n++) begin
      logic              rWe;
      logic [ADDR_W-1:0] rAddr;
      logic [LEN_W-1:0]  rLen;
      int                rStallAfter;
      int                rStallCycles;
      rnd = $urandom();
      rWe  = rnd[0];
      rLen = rnd[3:1];
      if (rnd[5:4] == 2'b00) rAddr = ADDR_W'(DEPTH - int'($urandom_range(1, 8)));
      else                   rAddr = rnd[18:6];
      rStallAfter  = int'($urandom_range(0, int'(rLen) + 1)) - 1;
      rStallCycles = int'($urandom_range(0, 3));
      for (int i = 0; i < 8; i++) begin
        rnd = $urandom();
        wbuf[i] = rnd[DATA_W-1:0];
      end
      applyStimulus(rWe, rAddr, rLen, rStallAfter, rStallCycles);
      if ($urandom_range(0, 2) != 0) begin
        @(negedge clk); #1;
        checkQueues();
        @(posedge clk); #1;
      end
    end
    @(negedge clk); #1;
    checkQueues();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
